// File: rtl/fifo_param_if.sv
// Signal bundle between a producer/consumer and fifo_param.
// The master side drives requests and data; the slave side (the FIFO) drives data and status.
interface fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic              write_enb;
  logic [WIDTH-1:0]  datain;
  logic              read_enb;
  logic [WIDTH-1:0]  dataout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, write_enb, datain, read_enb,
    input  dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, write_enb, datain, read_enb,
    output dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// occupancy count, programmable almost flags, synchronous flush and sticky error flags.
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic          clk,
  input  logic          reset,
  fifo_param_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_THR  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_THR  = (ADDR_W+1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;

  logic [ADDR_W:0]  w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Extra MSB on each pointer distinguishes a full FIFO from an empty one.
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_wr_ok = bus.write_enb && !w_full  && !bus.flush;
  assign w_rd_ok = bus.read_enb  && !w_empty && !bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_ok)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (bus.write_enb && w_full)
        r_overflow <= 1'b1;
      if (bus.read_enb && w_empty)
        r_underflow <= 1'b1;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.datain;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dataout = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    end else begin : g_std
      logic [WIDTH-1:0] r_dataout;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          r_dataout <= '0;
        else if (bus.flush)
          r_dataout <= '0;
        else if (w_rd_ok)
          r_dataout <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      end

      assign bus.dataout = r_dataout;
    end
  endgenerate

  assign bus.count        = w_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (w_count >= AF_THR);
  assign bus.almost_empty = (w_count <= AE_THR);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a standard-mode 8x32 instance and an FWFT 8x8 instance,
// checked against a queue-based model plus hand-written corner-case sequences.
module tb_fifo_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_param_if #(.WIDTH(8), .DEPTH(32)) bus0 ();
  fifo_param_if #(.WIDTH(8), .DEPTH(8))  bus1 ();

  fifo_param #(.WIDTH(8), .DEPTH(32), .FWFT(0), .AF_LEVEL(28), .AE_LEVEL(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  // Reference model: a queue of stored words plus sticky flags.
  logic [7:0] m_q[$];
  int         m_depth;
  int         m_af;
  int         m_ae;
  bit         m_fwft;
  bit         m_ovf;
  bit         m_unf;
  logic [7:0] m_dout;

  typedef struct {
    bit         we;
    logic [7:0] din;
    bit         re;
    bit         fl;
    int         e_count;
    logic [7:0] e_dout;
    bit         e_empty;
    bit         e_ovf;
    bit         e_unf;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int c, input bit f, input bit e, input bit af,
                                     input bit ae, input bit ov, input bit un, input logic [7:0] d);
    return {12'b0, 6'(c), f, e, af, ae, ov, un, d};
  endfunction

  function automatic logic [31:0] act_pack();
    if (sel == 0)
      return {12'b0, bus0.count, bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
              bus0.overflow, bus0.underflow, bus0.dataout};
    else
      return {12'b0, 2'b0, bus1.count, bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
              bus1.overflow, bus1.underflow, bus1.dataout};
  endfunction

  function automatic logic [31:0] exp_pack();
    int n;
    logic [7:0] d;
    n = m_q.size();
    if (m_fwft)
      d = (n > 0) ? m_q[0] : 8'h00;
    else
      d = m_dout;
    return mk(n, n == m_depth, n == 0, n >= m_af, n <= m_ae, m_ovf, m_unf, d);
  endfunction

  // Subset used by the vector table: count, empty, overflow, underflow, dataout.
  function automatic logic [31:0] act_sub();
    logic [31:0] p;
    p = act_pack();
    return {8'b0, 2'b0, p[19:14], 5'b0, p[12], p[9], p[8], p[7:0]};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = 8'h00;
  endtask

  task automatic model_step(input bit we, input logic [7:0] din, input bit re, input bit fl);
    int n;
    n = m_q.size();
    if (fl) begin
      model_reset();
    end else begin
      if (we && n == m_depth) m_ovf = 1'b1;
      if (re && n == 0)       m_unf = 1'b1;
      if (re && n > 0)        m_dout = m_q.pop_front();
      if (we && n < m_depth)  m_q.push_back(din);
    end
  endtask

  task automatic drive(input bit we, input logic [7:0] din, input bit re, input bit fl);
    if (sel == 0) begin
      bus0.write_enb = we; bus0.datain = din; bus0.read_enb = re; bus0.flush = fl;
    end else begin
      bus1.write_enb = we; bus1.datain = din; bus1.read_enb = re; bus1.flush = fl;
    end
  endtask

  // One clock transaction: drive, clock, advance model, compare everything, return to idle.
  task automatic cyc(input bit we, input logic [7:0] din, input bit re, input bit fl, input string name);
    logic [31:0] a;
    drive(we, din, re, fl);
    @(posedge clk);
    model_step(we, din, re, fl);
    #1;
    a = act_pack();
    $display("[TB] dut%0d %s we=%0d re=%0d fl=%0d din=%h -> count=%0d empty=%0d dout=%h",
             sel, name, we, re, fl, din, a[19:14], a[12], a[7:0]);
    chk(name, a, exp_pack());
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic set_cfg(input int d);
    sel = d;
    if (d == 0) begin
      m_depth = 32; m_af = 28; m_ae = 4; m_fwft = 1'b0;
    end else begin
      m_depth = 8;  m_af = 6;  m_ae = 1; m_fwft = 1'b1;
    end
    model_reset();
  endtask

  initial begin
    // FWFT vector table, starting from an empty FIFO.
    vt[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 8'hA1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'hB2, 1'b0, 1'b0, 2, 8'hA1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'hB2, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1, 8'hC3, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 8'hD4, 1'b1, 1'b0, 1, 8'hD4, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[8] = '{1'b1, 8'hE5, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[9] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 8'h11, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    sel = 1; drive(1'b0, 8'h00, 1'b0, 1'b0);
    sel = 0; drive(1'b0, 8'h00, 1'b0, 1'b0);
    set_cfg(0);

    // Reset values on both instances
    #2;
    chk("reset_dut0", act_pack(), mk(0, 0, 1, 0, 1, 0, 0, 8'h00));
    sel = 1;
    chk("reset_dut1", act_pack(), mk(0, 0, 1, 0, 1, 0, 0, 8'h00));
    sel = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, "idle");

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      if (i == 26) chk("af_at_27", 32'(bus0.almost_full), 32'd0);
      if (i == 27) chk("af_at_28", 32'(bus0.almost_full), 32'd1);
    end
    chk("fill_full", {31'b0, bus0.full}, 32'd1);
    chk("fill_count", 32'(bus0.count), 32'd32);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, "write_full");
    chk("overflow_set", {31'b0, bus0.overflow}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      chk("drain_data", 32'(bus0.dataout), 32'(i));
    end
    chk("drain_empty", {31'b0, bus0.empty}, 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "read_empty");
    chk("underflow_set", {31'b0, bus0.underflow}, 32'd1);
    chk("underflow_hold", 32'(bus0.dataout), 32'h1F);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "flush");

    // Wrap and sustained simultaneous access at count 1
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i + 100), 1'b0, 1'b0, "wr20");
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "rd20");
    cyc(1'b1, 8'h80, 1'b0, 1'b0, "seed");
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 8'(k), 1'b1, 1'b0, "stream");
      chk("stream_data", 32'(bus0.dataout), (k == 0) ? 32'h80 : 32'(k - 1));
    end
    chk("stream_count", 32'(bus0.count), 32'd1);

    // Simultaneous read and write while full
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "flush");
    for (int j = 0; j < 32; j++) cyc(1'b1, 8'(j + 8'h40), 1'b0, 1'b0, "fill2");
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, "rw_full");
    chk("rw_full", act_pack(), mk(31, 0, 0, 1, 0, 1, 0, 8'h40));

    // Flush with write, from count 10 with overflow set
    for (int j = 0; j < 21; j++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "rd21");
    chk("pre_flush", {bus0.overflow, 31'(bus0.count)}, {1'b1, 31'd10});
    cyc(1'b1, 8'h77, 1'b0, 1'b1, "flush_we");
    chk("flush_we", act_pack(), mk(0, 0, 1, 0, 1, 0, 0, 8'h00));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, "post_flush");
    chk("flush_nowrite", 32'(bus0.count), 32'd0);

    // Asynchronous reset in the middle of a cycle
    for (int j = 0; j < 6; j++) cyc(1'b1, 8'(j + 8'h30), 1'b0, 1'b0, "wr6");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "rd1");
    chk("pre_reset", {8'(bus0.count), 16'h0, bus0.dataout}, {8'd5, 16'h0, 8'h30});
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", act_pack(), mk(0, 0, 1, 0, 1, 0, 0, 8'h00));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, "post_reset");

    // FWFT instance
    set_cfg(1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "flush");
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, "fwft_wr");
    chk("fwft_visible", {bus1.empty, 23'b0, bus1.dataout}, {1'b0, 23'b0, 8'h5A});
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "fwft_pop");
    chk("fwft_pop", {bus1.empty, 23'b0, bus1.dataout}, {1'b1, 23'b0, 8'h00});
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, "fwft_fill");
      if (i == 0) chk("ae_at_1", 32'(bus1.almost_empty), 32'd1);
      if (i == 1) chk("ae_at_2", 32'(bus1.almost_empty), 32'd0);
      if (i == 4) chk("af_at_5", 32'(bus1.almost_full), 32'd0);
      if (i == 5) chk("af_at_6", 32'(bus1.almost_full), 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "flush");
    for (int i = 0; i < 10; i++) begin
      cyc(vt[i].we, vt[i].din, vt[i].re, vt[i].fl, "vector");
      chk("vector", act_sub(),
          {8'b0, 8'(vt[i].e_count), 5'b0, vt[i].e_empty, vt[i].e_ovf, vt[i].e_unf, vt[i].e_dout});
    end

    // Randomised traffic on both instances, alternating write-heavy and read-heavy phases
    for (int d = 0; d < 2; d++) begin
      set_cfg(d);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, "flush");
      for (int k = 0; k < 400; k++) begin
        int  wp;
        bit  we;
        bit  re;
        bit  fl;
        wp = ((k / 100) % 2 == 0) ? 75 : 25;
        we = ($urandom_range(0, 99) < wp);
        re = ($urandom_range(0, 99) < (100 - wp));
        fl = ($urandom_range(0, 199) == 0);
        cyc(we, 8'($urandom), re, fl, "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, successor to the fixed 8x32 FIFO. Configurable data width and depth, selectable standard or first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags. Single clock domain. Used as the general buffering element between producer and consumer blocks.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 32, number of entries; power of two, ≥4; ADDR_W = log2(DEPTH)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- AF_LEVEL, DEPTH-4, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of pointers, count and error flags
- write_enb  in  1  write request
- datain  in  WIDTH  write data
- read_enb  in  1  read request
- dataout  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH register array, not reset; contents after reset are don't-care.
- Pointers: write_ptr, read_ptr, each ADDR_W+1 bits; low ADDR_W bits address, MSB is wrap bit. full = MSBs differ and low bits equal; empty = pointers equal. count = write_ptr − read_ptr modulo 2^(ADDR_W+1).
- Write accepted (wr_ok) iff write_enb && !full. On wr_ok: mem[write_ptr[ADDR_W-1:0]] <= datain, write_ptr += 1.
- Read accepted (rd_ok) iff read_enb && !empty. On rd_ok: read_ptr += 1.
- Flags are evaluated on the pre-edge state. Simultaneous write and read:
  - neither full nor empty: both accepted, count unchanged.
  - full: read accepted, write rejected, overflow set.
  - empty: write accepted, read rejected, underflow set.
- Standard mode (FWFT=0): on rd_ok, dataout <= mem[read_ptr]; otherwise dataout holds.
- FWFT mode (FWFT=1): dataout = mem[read_ptr] combinationally when !empty, forced to 0 when empty; read_enb acknowledges and pops the displayed word.
- overflow sets on write_enb && full. underflow sets on read_enb && empty. Both stay set until reset or flush.
- flush: pointers set to 0, overflow and underflow cleared; dataout set to 0 in standard mode. Flush overrides write_enb and read_enb in the same cycle; nothing is written or read.
- Pointer wrap: low bits roll DEPTH-1 → 0, MSB toggles; wrap is transparent to count and flags.

## Timing
- Reset (reset=0, asynchronous): write_ptr=read_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0), overflow=underflow=0, dataout=0. Release is synchronous to the next clk edge. Reset during an operation aborts it immediately.
- All flags and count derive combinationally from the registered pointers, so they update in the same cycle as the edge that moves a pointer.
- Write at edge N: empty deasserts, count increments, after edge N.
- Standard-mode read latency: read_enb at edge N → data valid on dataout after edge N, held until the next rd_ok, flush or reset.
- FWFT latency: word written at edge N into an empty FIFO is visible on dataout after edge N. Pop at edge M shows the next word (or 0 if now empty) after edge M.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset/idle (WIDTH=8, DEPTH=32, FWFT=0): reset=0 → empty=1, full=0, count=0, dataout=0, overflow=underflow=0. Release, hold idle 5 cycles → outputs unchanged.
- Fill and drain: write 0x00..0x1F → full=1, count=32, almost_full from count=28. Extra write of 0xAA → overflow=1, 0xAA not stored. Read 32 → dataout 0x00..0x1F in order, empty=1. Extra read → underflow=1, dataout holds 0x1F.
- Wrap and simultaneous access: write 20, read 20, then stream 100 words with write_enb=read_enb=1 from count=1 → count stays 1, order preserved across pointer wrap. Simultaneous read+write at full → count 32→31, overflow=1.
- FWFT (FWFT=1, DEPTH=8): write 0x5A into empty FIFO → dataout=0x5A and empty=0 after the same edge, before any read. Pop → dataout=0, empty=1. Thresholds AF_LEVEL=6, AE_LEVEL=1 toggle at count 6 and 1.
- Flush and async reset: with count=10, overflow=1, assert flush together with write_enb → count=0, empty=1, overflow=0, word not written. With count=5, assert reset mid-cycle → all outputs return to reset values before the next edge.
